// File: rtl/mc_pkg.sv
// Shared types for the multicycle MIPS main controller.
// Holds opcodes, the FSM state enum and the per-state control word.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } statetype;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_rom.sv
// Combinational state -> control word map for mc_main_fsm.
// Ports: state (in), ctrl (out). FETCH strobes are ungated here.
module mc_ctrl_rom
    import mc_pkg::*;
(
    input  statetype state,
    output ctrl_t    ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.alusrcb = 2'b01;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                ctrl.alusrcb = 2'b11;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = 2'b10;
            end
            S_ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = 2'b01;
                ctrl.pcsrc   = 2'b01;
                ctrl.branch  = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            S_JUMP: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle MIPS main control FSM with memory-ready stalls and instret.
// Ports: clk, reset_n, op, mem_ready -> datapath enables/selects,
// illegal_op, instret. Macro MC_BNE_EN adds BNE and output branch_ne.
module mc_main_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             branch,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             illegal_op,
`ifdef MC_BNE_EN
    output logic             branch_ne,
`endif
    output logic [CNT_W-1:0] instret
);

    statetype state, nxt;
    ctrl_t    c;
    logic     retire;
    logic     illegal;
    logic     is_mem, is_rt, is_br;
    logic     is_addi, is_j, is_bne;

    mc_ctrl_rom u_rom (
        .state (state),
        .ctrl  (c)
    );

    assign is_mem  = (op == OP_LW) | (op == OP_SW);
    assign is_rt   = (op == OP_RTYPE);
    assign is_addi = (op == OP_ADDI);
    assign is_j    = (op == OP_J);
`ifdef MC_BNE_EN
    assign is_bne  = (op == OP_BNE);
`else
    assign is_bne  = 1'b0;
`endif
    assign is_br   = (op == OP_BEQ) | is_bne;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt     = state;
        retire  = 1'b0;
        illegal = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (mem_ready) nxt = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_mem:  nxt = S_MEMADR;
                    is_rt:   nxt = S_EXECUTE;
                    is_br:   nxt = S_BRANCH;
                    is_addi: nxt = S_ADDIEX;
                    is_j:    nxt = S_JUMP;
                    default: begin
                        nxt     = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end
            end
            S_EXECUTE: nxt = S_ALUWB;
            S_ALUWB: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            S_BRANCH: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            S_ADDIEX: nxt = S_ADDIWB;
            S_ADDIWB: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            S_JUMP: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + CNT_W'(1);
        end
    end

    // FETCH strobes wait for memory; reset_n masks every write
    // strobe so none can fire while reset is held.
    logic fetch_go;
    assign fetch_go = (state != S_FETCH) | mem_ready;

    assign iord       = c.iord;
    assign memwrite   = c.memwrite & reset_n;
    assign irwrite    = c.irwrite & mem_ready & reset_n;
    assign pcwrite    = c.pcwrite & fetch_go & reset_n;
    assign pcsrc      = c.pcsrc;
    assign alusrca    = c.alusrca;
    assign alusrcb    = c.alusrcb;
    assign aluop      = c.aluop;
    assign regdst     = c.regdst;
    assign memtoreg   = c.memtoreg;
    assign regwrite   = c.regwrite & reset_n;
    assign illegal_op = illegal;

`ifdef MC_BNE_EN
    assign branch     = c.branch & ~is_bne;
    assign branch_ne  = c.branch & is_bne;
`else
    assign branch     = c.branch;
`endif

endmodule

// File: tb/tb_mc_main_fsm.sv
// Self-checking bench for mc_main_fsm with random stalls and ops.
// Expected per-cycle controls come from an instruction-level model.
module tb_mc_main_fsm;

    localparam int CNT_W = 4;

    localparam logic [5:0] T_RT   = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BNE  = 6'b000101;
`ifdef MC_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [5:0]       op;
    logic             mem_ready;
    logic             iord, memwrite, irwrite, pcwrite, branch;
    logic [1:0]       pcsrc, alusrcb, aluop;
    logic             alusrca, regdst, memtoreg, regwrite;
    logic             illegal_op;
    logic             branch_ne_o;
    logic [CNT_W-1:0] instret;

    mc_main_fsm #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .pcsrc      (pcsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .illegal_op (illegal_op),
`ifdef MC_BNE_EN
        .branch_ne  (branch_ne_o),
`endif
        .instret    (instret)
    );
`ifndef MC_BNE_EN
    assign branch_ne_o = 1'b0;
`endif

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] m_instret;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       branch_ne;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal_op;
    } exp_t;

    typedef struct packed {
        logic mr;
        exp_t e;
    } step_t;

    step_t steps[$];

    function automatic exp_t observed();
        exp_t o;
        o            = '0;
        o.iord       = iord;
        o.memwrite   = memwrite;
        o.irwrite    = irwrite;
        o.pcwrite    = pcwrite;
        o.branch     = branch;
        o.branch_ne  = branch_ne_o;
        o.pcsrc      = pcsrc;
        o.alusrca    = alusrca;
        o.alusrcb    = alusrcb;
        o.aluop      = aluop;
        o.regdst     = regdst;
        o.memtoreg   = memtoreg;
        o.regwrite   = regwrite;
        o.illegal_op = illegal_op;
        return o;
    endfunction

    function automatic bit legal(input logic [5:0] o);
        return o == T_RT || o == T_LW || o == T_SW ||
               o == T_BEQ || o == T_ADDI || o == T_J ||
               (BNE_EN && o == T_BNE);
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    task automatic add(input logic mr, input exp_t e);
        step_t s;
        s.mr = mr;
        s.e  = e;
        steps.push_back(s);
    endtask

    // Instruction fetch: stalls cycles with ready low, then one ready.
    task automatic plan_fetch(input int stalls);
        exp_t e;
        for (int i = 0; i <= stalls; i++) begin
            e         = '0;
            e.alusrcb = 2'b01;
            e.irwrite = (i == stalls);
            e.pcwrite = (i == stalls);
            add(i == stalls, e);
        end
    endtask

    task automatic plan_mem(input int stalls, input bit wr);
        exp_t e;
        for (int i = 0; i <= stalls; i++) begin
            e          = '0;
            e.iord     = 1'b1;
            e.memwrite = wr;
            add(i == stalls, e);
        end
    endtask

    // Expected cycle-by-cycle controls for one instruction.
    task automatic plan_instr(input logic [5:0] o, input int fs,
                              input int ms);
        exp_t e;
        plan_fetch(fs);
        e            = '0;
        e.alusrcb    = 2'b11;
        e.illegal_op = !legal(o);
        add(rnd(), e);
        if (o == T_LW || o == T_SW) begin
            e         = '0;
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
            add(rnd(), e);
            plan_mem(ms, o == T_SW);
            if (o == T_LW) begin
                e          = '0;
                e.memtoreg = 1'b1;
                e.regwrite = 1'b1;
                add(rnd(), e);
            end
        end else if (o == T_RT) begin
            e         = '0;
            e.alusrca = 1'b1;
            e.aluop   = 2'b10;
            add(rnd(), e);
            e          = '0;
            e.regdst   = 1'b1;
            e.regwrite = 1'b1;
            add(rnd(), e);
        end else if (o == T_BEQ || (BNE_EN && o == T_BNE)) begin
            e           = '0;
            e.alusrca   = 1'b1;
            e.aluop     = 2'b01;
            e.pcsrc     = 2'b01;
            e.branch    = (o == T_BEQ);
            e.branch_ne = (o == T_BNE);
            add(rnd(), e);
        end else if (o == T_ADDI) begin
            e         = '0;
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
            add(rnd(), e);
            e          = '0;
            e.regwrite = 1'b1;
            add(rnd(), e);
        end else if (o == T_J) begin
            e         = '0;
            e.pcsrc   = 2'b10;
            e.pcwrite = 1'b1;
            add(rnd(), e);
        end
    endtask

    task automatic play(input string name, input logic [5:0] o);
        step_t s;
        exp_t  ob;
        int    cyc;
        cyc = 0;
        while (steps.size() > 0) begin
            s = steps.pop_front();
            @(negedge clk);
            op        = o;
            mem_ready = s.mr;
            #1;
            ob = observed();
            checks++;
            if (ob !== s.e) begin
                failures++;
                $display("FAIL %s cyc%0d ctrl got=%h want=%h",
                         name, cyc, ob, s.e);
            end
            checks++;
            if (instret !== m_instret) begin
                failures++;
                $display("FAIL %s cyc%0d instret got=%0d want=%0d",
                         name, cyc, instret, m_instret);
            end
            if (regwrite && memwrite) begin
                failures++;
                $display("FAIL %s cyc%0d regwrite&memwrite", name, cyc);
            end
            cyc++;
        end
    endtask

    task automatic run_instr(input string name, input logic [5:0] o,
                             input int fs, input int ms);
        plan_instr(o, fs, ms);
        play(name, o);
        if (legal(o)) m_instret = m_instret + 1'b1;
    endtask

    task automatic check_in_reset(input string name);
        exp_t e;
        e         = '0;
        e.alusrcb = 2'b01;
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL %s ctrl got=%h want=%h", name, observed(), e);
        end
        checks++;
        if (instret !== '0) begin
            failures++;
            $display("FAIL %s instret got=%0d want=0", name, instret);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_in_reset("reset_dut");
        @(negedge clk);
        reset_n   = 1'b1;
        m_instret = '0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        op        = T_ADDI;
        #2;
        check_in_reset("reset_initial");
        repeat (2) @(posedge clk);
        #1;
        check_in_reset("reset_held");
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        m_instret = '0;
        run_instr("rst_addi", T_ADDI, 0, 0);
        // Start an RTYPE and abandon it in EXECUTE.
        plan_fetch(0);
        begin
            exp_t e;
            e         = '0;
            e.alusrcb = 2'b11;
            add(1'b1, e);
            e         = '0;
            e.alusrca = 1'b1;
            e.aluop   = 2'b10;
            add(1'b1, e);
        end
        play("rst_exec", T_RT);
        #1;
        reset_n = 1'b0;
        #1;
        check_in_reset("reset_mid_exec");
        @(posedge clk);
        #1;
        check_in_reset("reset_mid_held");
        @(negedge clk);
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        m_instret = '0;
    endtask

    task automatic test_lw();
        run_instr("lw", T_LW, 0, 0);
    endtask

    task automatic test_sw_wait();
        run_instr("sw_wait", T_SW, 2, 3);
    endtask

    task automatic test_mixed();
        run_instr("mix_rt", T_RT, 0, 0);
        run_instr("mix_addi", T_ADDI, 0, 0);
        run_instr("mix_beq", T_BEQ, 0, 0);
        run_instr("mix_j", T_J, 0, 0);
        run_instr("mix_lw_wait", T_LW, 1, 2);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 6'b111111, 0, 0);
        run_instr("bne", T_BNE, 0, 0);
        run_instr("after_ill", T_ADDI, 1, 0);
    endtask

    task automatic test_wrap();
        reset_dut();
        for (int i = 0; i < 17; i++) run_instr("wrap", T_ADDI, 0, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (instret !== 4'd1) begin
            failures++;
            $display("FAIL wrap_final instret got=%0d want=1", instret);
        end
    endtask

    task automatic test_random();
        logic [5:0] tbl [8];
        logic [5:0] o;
        tbl[0] = T_RT;
        tbl[1] = T_LW;
        tbl[2] = T_SW;
        tbl[3] = T_BEQ;
        tbl[4] = T_ADDI;
        tbl[5] = T_J;
        tbl[6] = T_BNE;
        tbl[7] = 6'b111111;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) o = 6'($urandom);
            else o = tbl[$urandom_range(0, 7)];
            run_instr("random", o, $urandom_range(0, 2),
                      $urandom_range(0, 3));
        end
    endtask

    initial begin
        m_instret = '0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_mixed();
        test_illegal();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_main_fsm.md
Name: mc_main_fsm

Overview:
- Main control state machine for the multicycle MIPS datapath. It replaces the single-cycle main decoder with a sequenced controller.
- It steps each instruction through fetch, decode, execute, memory and writeback. It drives the per-cycle datapath enables and mux selects.
- It stalls on a shared instruction/data memory via a ready handshake and counts retired instructions.
- It sits beside the ALU decoder inside the multicycle controller.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  6  opcode field of the instruction register.
- mem_ready  in  1  memory has completed the current access this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- pcwrite  out  1  unconditional PC load.
- branch  out  1  conditional PC load; the datapath ANDs it with zero.
- pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alusrca  out  1  ALU A: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- aluop  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct.
- regdst  out  1  destination register: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback source: 0 = ALUOut, 1 = Data.
- regwrite  out  1  register file write.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Moore FSM. All outputs except the memory-gated strobes depend only on the state register. Every control output not listed for a state is 0.
- States, with asserted controls and next state:
  - FETCH: alusrcb=01. While mem_ready=0, irwrite=pcwrite=0 and the FSM holds. When mem_ready=1, irwrite=pcwrite=1 and next state is DECODE.
  - DECODE: alusrcb=11. Next state by op:
    - LW 100011 and SW 101011 -> MEMADR
    - RTYPE 000000 -> EXECUTE
    - BEQ 000100 -> BRANCH
    - ADDI 001000 -> ADDIEX
    - J 000010 -> JUMP
    - any other op -> FETCH with illegal_op=1 for that cycle.
  - MEMADR: alusrca=1, alusrcb=10. LW -> MEMRD, SW -> MEMWR.
  - MEMRD: iord=1. Holds until mem_ready=1, then -> MEMWB.
  - MEMWB: memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR: iord=1, memwrite=1 for the whole wait. Holds until mem_ready=1, then -> FETCH.
  - EXECUTE: alusrca=1, aluop=10 -> ALUWB.
  - ALUWB: regdst=1, regwrite=1 -> FETCH.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1 -> FETCH.
  - ADDIEX: alusrca=1, alusrcb=10 -> ADDIWB.
  - ADDIWB: regwrite=1 -> FETCH.
  - JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- op is sampled from the instruction register. It is stable from DECODE until the next FETCH completes.
- Cycle counts with mem_ready always 1:
  - LW: 5 cycles.
  - RTYPE, SW, ADDI: 4 cycles.
  - BEQ, J: 3 cycles.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- instret increments by 1 on the edge leaving the final state of each legal instruction:
  - from MEMWB, MEMWR (when ready), ALUWB, BRANCH, ADDIWB or JUMP.
  - An illegal opcode does not increment it. The counter wraps modulo 2^CNT_W.
- Reset:
  - reset_n=0 forces state to FETCH, instret to 0 and illegal_op to 0 immediately, regardless of clk.
  - Reset mid-instruction abandons the instruction. No write strobe is asserted after reset assertion.
  - After reset deassertion, the first fetch begins on the next edge.
- The FSM never issues regwrite and memwrite in the same cycle.

Optional Feature:
- Macro MC_BNE_EN.
- Defined:
  - Adds output branch_ne (1 bit) and opcode BNE 000101.
  - DECODE routes BNE to BRANCH. In BRANCH, branch_ne is asserted instead of branch when the latched op is BNE.
  - The datapath uses (branch & zero) | (branch_ne & ~zero).
- Undefined:
  - Port branch_ne is absent. BNE is illegal and pulses illegal_op.

Decomposition:
- Package mc_pkg holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE.
  - typedef enum logic [3:0] statetype for the twelve states.
  - packed struct typedef ctrl_t for the control word.
- One sub-module, mc_ctrl_rom: a combinational map from statetype to ctrl_t. The top module keeps the state register, next-state logic, mem_ready gating and counter.

Test Plan:
- Reset: hold reset_n=0 mid-EXECUTE, then release -> state FETCH, instret=0, all strobes 0 while in reset.
- LW, mem_ready=1: op=100011 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 and memtoreg=1 on cycle 5 only. instret goes 0 -> 1.
- SW with memory wait: op=101011 and mem_ready=0 for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then FETCH. irwrite pulses exactly once per fetch despite a 2-cycle fetch stall.
- Mixed stream RTYPE, ADDI, BEQ, J -> 4, 4, 3, 3 cycles. aluop is 10 in EXECUTE and 01 in BRANCH. pcsrc=10 with pcwrite in JUMP. instret=4.
- Illegal op=111111 -> illegal_op pulses one cycle in DECODE, then FETCH, instret unchanged. With MC_BNE_EN, op=000101 -> BRANCH with branch_ne=1 and branch=0.
- Counter wrap with CNT_W=4: 17 ADDIs -> instret=1.
